ram_sequencer: RTL and testbench
================================

// Module: ram_sequencer
// PURPOSE
//   Self-sequencing single-port RAM: no address or data inputs. After reset it fills every
//   word with a deterministic pattern (FILL), then scans the addresses forever (READ),
//   presenting each word on ram_out. Serves as a clock-only datapath demo/stimulus source.
// PARAMETERS
//   ADDR_W  4     address width; DEPTH = 2**ADDR_W words (legal range 2..8)
//   SEED    8'h10 fill pattern base: word i is written with (SEED + i) mod 256
// PORTS
//   clock    input   1  single clock; all state changes on the rising edge
//   reset_n  input   1  synchronous, active-low reset, sampled on the rising clock edge
//   ram_out  output  8  registered read data
// BEHAVIOUR
//   - Reset: reset_n low at a rising edge -> state=FILL, addr=0, ram_out=8'h00.
//     Memory contents are not cleared; FILL overwrites them.
//   - Edge numbering: edge 1 is the first rising edge with reset_n high.
//   - FILL: each edge writes mem[addr] <= SEED+addr (8-bit wrap) and increments addr.
//     ram_out holds 8'h00. Edges 1..DEPTH write addresses 0..DEPTH-1. At edge DEPTH,
//     addr wraps to 0 and state becomes READ.
//   - READ: each edge does ram_out <= mem[addr] and addr <= addr+1 (wraps DEPTH-1 -> 0).
//     Read latency is 1 cycle (synchronous read).
//     After edge DEPTH+1+i, ram_out = mem[i mod DEPTH].
//   - READ is terminal; only reset returns to FILL.
//   - Reset mid-FILL or mid-READ: restarts at FILL with addr 0 and refills all words.
//   - addr is ADDR_W bits and wraps naturally; no full/empty flags. Data is 8 bits; sums wrap mod 256.
//   - ram_out never shows X after the first reset.
// CONFIGURATION
//   RAM_INC_WRITEBACK_EN defined:
//     - On each READ edge, also write mem[addr] <= mem[addr]+1 (8-bit wrap).
//     - Read-before-write: ram_out gets the old value.
//     - Each full pass therefore shows values 1 higher than the previous pass.
//   RAM_INC_WRITEBACK_EN undefined:
//     - READ never writes; the pattern repeats identically every DEPTH cycles.
// STRUCTURE
//   - Package ram_sequencer_pkg:
//     - state typedef (enum {FILL, READ}, 1 bit)
//     - DATA_W=8 localparam
//     - reset value 8'h00 for ram_out
//   - Sub-module sp_ram_core:
//     - DEPTH x 8 single-port synchronous memory
//     - ports: clock, we, addr, wdata, rdata
//     - read-before-write on a same-address access; registered rdata
//   - Top level holds the address counter and FILL/READ FSM.
//     It drives sp_ram_core and gates ram_out to 0 during FILL.
// TESTING (defaults ADDR_W=4, SEED=8'h10, clock period 100 ps)
//   1 Hold reset_n=0 for 2 edges -> ram_out=8'h00; release, edges 1..16 -> ram_out stays 8'h00.
//   2 Edges 17..32 -> ram_out steps 8'h10,8'h11,...,8'h1F, one value per edge, no gaps.
//   3 Edge 33 -> ram_out=8'h10 without RAM_INC_WRITEBACK_EN; 8'h11 with it
//     (edge 48 -> 8'h1F / 8'h20).
//   4 Assert reset_n=0 at edge 22 (ram_out was 8'h14) -> ram_out=8'h00 next edge;
//     release -> 16 FILL edges of 8'h00, then 8'h10 again (refill also clears writeback increments).
//   5 SEED=8'hF8, ADDR_W=4 -> read sequence 8'hF8..8'hFF,8'h00..8'h07 (8-bit wrap).
//   6 ADDR_W=2 -> FILL lasts 4 edges, then repeating 8'h10,8'h11,8'h12,8'h13.

Source files
------------

// File: rtl/ram_sequencer_pkg.sv
// Shared types and constants for the self-sequencing RAM demo.
package ram_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] RAM_OUT_RST = 8'h00;

    typedef enum logic {
        FILL = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sequencer_if.sv
// Read-data bus presented by ram_sequencer to its consumer.
interface ram_sequencer_if;
    import ram_sequencer_pkg::*;

    logic [DATA_W-1:0] ram_out;

    modport master (output ram_out);
    modport slave  (input  ram_out);
endinterface

// File: rtl/sp_ram_core.sv
// DEPTH x DATA_W single-port synchronous RAM, registered read, read-before-write.
module sp_ram_core
    import ram_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter bit          INC_WB = 1'b0
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // With INC_WB, every non-write access increments the addressed word in place;
    // rdata still captures the pre-increment value.
    always_ff @(posedge clock) begin
        rdata <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
        end else if (INC_WB) begin
            mem[addr] <= mem[addr] + DATA_W'(1);
        end
    end

endmodule

// File: rtl/ram_sequencer.sv
// Fills the RAM with SEED+addr after reset, then scans it forever onto bus.ram_out.
// Optional macro RAM_INC_WRITEBACK_EN: each READ access also increments the word read.
module ram_sequencer
    import ram_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W = 4,
    parameter logic [DATA_W-1:0] SEED   = 8'h10
) (
    input  logic            clock,
    input  logic            reset_n,
    ram_sequencer_if.master bus
);

`ifdef RAM_INC_WRITEBACK_EN
    localparam bit INC_WB = 1'b1;
`else
    localparam bit INC_WB = 1'b0;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;

    // rd_valid tracks whether rdata came from a READ-state access, so the
    // last FILL-edge read never leaks onto ram_out.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= FILL;
            addr     <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            rd_valid <= (state == READ);
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr + ADDR_W'(1);
        we         = 1'b0;
        wdata      = SEED + DATA_W'(addr);
        case (state)
            FILL: begin
                we = 1'b1;
                if (addr == '1) begin
                    state_next = READ;
                end
            end
            READ: begin
                we = 1'b0;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    sp_ram_core #(
        .ADDR_W (ADDR_W),
        .INC_WB (INC_WB)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign bus.ram_out = rd_valid ? rdata : RAM_OUT_RST;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed self-checking bench: default, wrapped-seed and 4-word instances share clock/reset.
module tb_ram_sequencer;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

`ifdef RAM_INC_WRITEBACK_EN
    localparam logic [7:0] WB = 8'd1;
`else
    localparam logic [7:0] WB = 8'd0;
`endif

    ram_sequencer_if bus_m ();
    ram_sequencer_if bus_w ();
    ram_sequencer_if bus_s ();

    ram_sequencer #(.ADDR_W(4), .SEED(8'h10)) dut_main (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    ram_sequencer #(.ADDR_W(4), .SEED(8'hF8)) dut_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    ram_sequencer #(.ADDR_W(2), .SEED(8'h10)) dut_small (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus_m.ram_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_main got=%h exp=%h", bus_m.ram_out, 8'h00);
        end
        checks++;
        if (bus_w.ram_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_wrap got=%h exp=%h", bus_w.ram_out, 8'h00);
        end
        checks++;
        if (bus_s.ram_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_small got=%h exp=%h", bus_s.ram_out, 8'h00);
        end
        reset_n = 1'b1;
    endtask

    // Edges 1..16: both 16-word instances are filling and must output zero.
    task automatic test_fill();
        for (int n = 1; n <= 16; n++) begin
            step();
            checks++;
            if (bus_m.ram_out !== 8'h00) begin
                failures++;
                $display("FAIL fill_main edge=%0d got=%h exp=%h", n, bus_m.ram_out, 8'h00);
            end
            checks++;
            if (bus_w.ram_out !== 8'h00) begin
                failures++;
                $display("FAIL fill_wrap edge=%0d got=%h exp=%h", n, bus_w.ram_out, 8'h00);
            end
        end
    endtask

    // Edges 17..32: first read pass.
    task automatic test_read_pass();
        logic [7:0] tbl [16];
        tbl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (bus_m.ram_out !== tbl[i]) begin
                failures++;
                $display("FAIL read_pass edge=%0d got=%h exp=%h", 17 + i, bus_m.ram_out, tbl[i]);
            end
        end
    endtask

    // Edges 33..48: second pass, shifted by one when writeback is enabled.
    task automatic test_second_pass();
        logic [7:0] tbl [16];
        logic [7:0] e;
        tbl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
        for (int i = 0; i < 16; i++) begin
            step();
            e = tbl[i] + WB;
            checks++;
            if (bus_m.ram_out !== e) begin
                failures++;
                $display("FAIL second_pass edge=%0d got=%h exp=%h", 33 + i, bus_m.ram_out, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        // Reset after writeback passes: refill must restore the base pattern.
        reset_n = 1'b0;
        step();
        checks++;
        if (bus_m.ram_out !== 8'h00) begin
            failures++;
            $display("FAIL midreset_read got=%h exp=%h", bus_m.ram_out, 8'h00);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            checks++;
            if (bus_m.ram_out !== 8'h00) begin
                failures++;
                $display("FAIL midreset_refill edge=%0d got=%h exp=%h", n, bus_m.ram_out, 8'h00);
            end
        end
        for (int n = 17; n <= 21; n++) begin
            step();
        end
        checks++;
        if (bus_m.ram_out !== 8'h14) begin
            failures++;
            $display("FAIL midreset_edge21 got=%h exp=%h", bus_m.ram_out, 8'h14);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (bus_m.ram_out !== 8'h00) begin
            failures++;
            $display("FAIL midreset_edge22 got=%h exp=%h", bus_m.ram_out, 8'h00);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            checks++;
            if (bus_m.ram_out !== 8'h00) begin
                failures++;
                $display("FAIL midreset_fill2 edge=%0d got=%h exp=%h", n, bus_m.ram_out, 8'h00);
            end
        end
        step();
        checks++;
        if (bus_m.ram_out !== 8'h10) begin
            failures++;
            $display("FAIL midreset_restart got=%h exp=%h", bus_m.ram_out, 8'h10);
        end
    endtask

    task automatic test_seed_wrap();
        logic [7:0] tbl [16];
        logic [7:0] e;
        tbl = '{8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF,
                8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (bus_w.ram_out !== tbl[i]) begin
                failures++;
                $display("FAIL seed_wrap edge=%0d got=%h exp=%h", 17 + i, bus_w.ram_out, tbl[i]);
            end
        end
        step();
        e = 8'hF8 + WB;
        checks++;
        if (bus_w.ram_out !== e) begin
            failures++;
            $display("FAIL seed_wrap_pass2 got=%h exp=%h", bus_w.ram_out, e);
        end
    endtask

    task automatic test_small_depth();
        logic [7:0] tbl [4];
        logic [7:0] e;
        tbl = '{8'h10, 8'h11, 8'h12, 8'h13};
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            checks++;
            if (bus_s.ram_out !== 8'h00) begin
                failures++;
                $display("FAIL small_fill edge=%0d got=%h exp=%h", n, bus_s.ram_out, 8'h00);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step();
            e = tbl[i % 4] + ((i / 4 == 0) ? 8'd0 : (i / 4 == 1) ? WB : 8'(2 * WB));
            checks++;
            if (bus_s.ram_out !== e) begin
                failures++;
                $display("FAIL small_read edge=%0d got=%h exp=%h", 5 + i, bus_s.ram_out, e);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        test_reset();
        test_fill();
        test_read_pass();
        test_second_pass();
        test_mid_reset();
        test_seed_wrap();
        test_small_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
